// File: rtl/entry_lockout_controller_if.sv
// Signal bundle between the board button/checker LEDs and the entry lockout controller.
// The controller takes the slave side; whatever drives the button and checker LEDs takes master.
interface entry_lockout_controller_if #(
   parameter int MAX_FAILS = 3
);
   localparam int FailW = $clog2(MAX_FAILS + 1);

   logic             btn_pulse_in;
   logic             chk_led_r_in;
   logic             chk_led_g_in;
   logic             chk_led_b_in;
   logic             chk_action_out;
   logic             chk_reset_out;
   logic             led_r_out;
   logic             led_g_out;
   logic             led_b_out;
   logic             locked_out;
   logic [FailW-1:0] fail_count_out;

   modport master (
      output btn_pulse_in, chk_led_r_in, chk_led_g_in, chk_led_b_in,
      input  chk_action_out, chk_reset_out, led_r_out, led_g_out, led_b_out,
      input  locked_out, fail_count_out
   );

   modport slave (
      input  btn_pulse_in, chk_led_r_in, chk_led_g_in, chk_led_b_in,
      output chk_action_out, chk_reset_out, led_r_out, led_g_out, led_b_out,
      output locked_out, fail_count_out
   );
endinterface

// File: rtl/entry_lockout_controller.sv
// Sits between the debounced button and the pattern checker: forwards actions, auto-acknowledges
// displayed results, counts consecutive failures and locks the checker out after too many.
module entry_lockout_controller #(
   parameter int MAX_FAILS      = 3,
   parameter int DISPLAY_CYCLES = 50_000_000,
   parameter int LOCKOUT_CYCLES = 100_000_000,
   parameter int BLINK_HALF     = 12_500_000
) (
   input logic                       clk,
   input logic                       reset,
   entry_lockout_controller_if.slave bus
);
   localparam int FailW    = $clog2(MAX_FAILS + 1);
   localparam int TimerMax = (LOCKOUT_CYCLES > DISPLAY_CYCLES) ? LOCKOUT_CYCLES : DISPLAY_CYCLES;
   localparam int TimerW   = $clog2(TimerMax);
   localparam int BlinkW   = $clog2(BLINK_HALF + 1);

   typedef enum logic [1:0] {
      PASS       = 2'd0,
      SHOW       = 2'd1,
      WAIT_CLEAR = 2'd2,
      LOCKOUT    = 2'd3
   } state_t;

   state_t            r_state;
   logic [FailW-1:0]  r_failCount;
   logic [TimerW-1:0] r_timer;
   logic [BlinkW-1:0] r_blinkCnt;
   logic              r_blinkOn;
   logic              r_action;
   logic              r_chkReset;
   logic              r_locked;

   logic w_showExpired;
   logic w_lockExpired;
   logic w_ledR;
   logic w_ledG;
   logic w_ledB;

   // SHOW pulses on the edge DISPLAY_CYCLES-1 after entry; LOCKOUT leaves LOCKOUT_CYCLES after entry.
   assign w_showExpired = (r_timer == TimerW'(DISPLAY_CYCLES - 2));
   assign w_lockExpired = (r_timer == TimerW'(LOCKOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= PASS;
         r_failCount <= '0;
         r_timer     <= '0;
         r_blinkCnt  <= '0;
         r_blinkOn   <= 1'b0;
         r_action    <= 1'b0;
         r_chkReset  <= 1'b1;
         r_locked    <= 1'b0;
      end else begin
         r_action <= 1'b0;
         unique case (r_state)
            PASS: begin
               r_chkReset <= 1'b0;
               r_timer    <= '0;
               r_blinkCnt <= '0;
               if (bus.chk_led_g_in) begin
                  r_failCount <= '0;
                  r_action    <= bus.btn_pulse_in;
                  r_state     <= bus.btn_pulse_in ? WAIT_CLEAR : SHOW;
               end else if (bus.chk_led_r_in) begin
                  // The failure that reaches the limit swallows any coincident button press.
                  if (r_failCount == FailW'(MAX_FAILS - 1)) begin
                     r_failCount <= FailW'(MAX_FAILS);
                     r_state     <= LOCKOUT;
                     r_chkReset  <= 1'b1;
                     r_locked    <= 1'b1;
                     r_blinkOn   <= 1'b1;
                  end else begin
                     r_failCount <= r_failCount + FailW'(1);
                     r_action    <= bus.btn_pulse_in;
                     r_state     <= bus.btn_pulse_in ? WAIT_CLEAR : SHOW;
                  end
               end else begin
                  r_action <= bus.btn_pulse_in;
               end
            end
            SHOW: begin
               if (bus.btn_pulse_in || w_showExpired) begin
                  r_action <= 1'b1;
                  r_state  <= WAIT_CLEAR;
                  r_timer  <= '0;
               end else begin
                  r_timer <= r_timer + TimerW'(1);
               end
            end
            WAIT_CLEAR: begin
               if (!bus.chk_led_r_in && !bus.chk_led_g_in) begin
                  r_state <= PASS;
               end
            end
            LOCKOUT: begin
               if (w_lockExpired) begin
                  r_state     <= PASS;
                  r_failCount <= '0;
                  r_chkReset  <= 1'b0;
                  r_locked    <= 1'b0;
                  r_timer     <= '0;
                  r_blinkCnt  <= '0;
               end else begin
                  r_timer <= r_timer + TimerW'(1);
                  if (r_blinkCnt == BlinkW'(BLINK_HALF - 1)) begin
                     r_blinkCnt <= '0;
                     r_blinkOn  <= ~r_blinkOn;
                  end else begin
                     r_blinkCnt <= r_blinkCnt + BlinkW'(1);
                  end
               end
            end
            default: r_state <= PASS;
         endcase
      end
   end

   // Board LEDs mirror the checker except during lockout, where only the blinking red shows.
   always_comb begin
      w_ledR = bus.chk_led_r_in;
      w_ledG = bus.chk_led_g_in;
      w_ledB = bus.chk_led_b_in;
      if (r_state == LOCKOUT) begin
         w_ledR = r_blinkOn;
         w_ledG = 1'b0;
         w_ledB = 1'b0;
      end
   end

   assign bus.led_r_out      = w_ledR;
   assign bus.led_g_out      = w_ledG;
   assign bus.led_b_out      = w_ledB;
   assign bus.chk_action_out = r_action;
   assign bus.chk_reset_out  = r_chkReset;
   assign bus.locked_out     = r_locked;
   assign bus.fail_count_out = r_failCount;
endmodule

// File: tb/tb_entry_lockout_controller.sv
// Self-checking bench for entry_lockout_controller: the bench plays the checker's LEDs and the
// button, predicts LEDs within each cycle and registered outputs after each edge.
module tb_entry_lockout_controller;
   typedef struct packed {
      logic       rstN;
      logic       btn;
      logic       r;
      logic       g;
      logic       b;
      logic       expAction;
      logic       expChkReset;
      logic       expLocked;
      logic [1:0] expFail;
      logic       expLedR;
      logic       expLedG;
      logic       expLedB;
   } vec_t;

   logic clk;
   logic reset;
   int   nCompared;
   int   nMismatched;
   int   stepNum;
   vec_t expQ[$];
   vec_t basicTable[$];
   vec_t failTable[$];

   entry_lockout_controller_if #(.MAX_FAILS(3)) bus ();

   entry_lockout_controller #(
      .MAX_FAILS     (3),
      .DISPLAY_CYCLES(8),
      .LOCKOUT_CYCLES(20),
      .BLINK_HALF    (4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic rstN, btn, r, g, b, expAction, expChkReset, expLocked,
                               input logic [1:0] expFail, input logic expLedR, expLedG, expLedB);
      vec_t v;
      v.rstN = rstN; v.btn = btn; v.r = r; v.g = g; v.b = b;
      v.expAction = expAction; v.expChkReset = expChkReset; v.expLocked = expLocked;
      v.expFail = expFail; v.expLedR = expLedR; v.expLedG = expLedG; v.expLedB = expLedB;
      return v;
   endfunction

   task automatic compare(input string name, input logic [1:0] actual, input logic [1:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s at step %0d: got %0b, expected %0b", name, stepNum, actual, expected);
      end
   endtask

   // Registered outputs are checked one edge after the vector that predicted them was driven.
   task automatic checkOutput();
      vec_t e;
      if (expQ.size() == 0) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL scoreboard at step %0d: queue empty, expected an entry", stepNum);
      end else begin
         e = expQ.pop_front();
         compare("chk_action_out", {1'b0, bus.chk_action_out}, {1'b0, e.expAction});
         compare("chk_reset_out",  {1'b0, bus.chk_reset_out},  {1'b0, e.expChkReset});
         compare("locked_out",     {1'b0, bus.locked_out},     {1'b0, e.expLocked});
         compare("fail_count_out", bus.fail_count_out,         e.expFail);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      stepNum++;
      reset            = v.rstN;
      bus.btn_pulse_in = v.btn;
      bus.chk_led_r_in = v.r;
      bus.chk_led_g_in = v.g;
      bus.chk_led_b_in = v.b;
      #1;
      compare("led_r_out", {1'b0, bus.led_r_out}, {1'b0, v.expLedR});
      compare("led_g_out", {1'b0, bus.led_g_out}, {1'b0, v.expLedG});
      compare("led_b_out", {1'b0, bus.led_b_out}, {1'b0, v.expLedB});
      expQ.push_back(v);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      nCompared        = 0;
      nMismatched      = 0;
      stepNum          = 0;
      clk              = 1'b0;
      reset            = 1'b0;
      bus.btn_pulse_in = 1'b0;
      bus.chk_led_r_in = 1'b0;
      bus.chk_led_g_in = 1'b0;
      bus.chk_led_b_in = 1'b0;

      // rstN btn r g b | action chkReset locked fail | ledR ledG ledB
      basicTable.push_back(mk(0,0,0,0,0, 0,1,0,2'd0, 0,0,0));
      basicTable.push_back(mk(1,0,0,0,0, 0,0,0,2'd0, 0,0,0));
      basicTable.push_back(mk(1,1,0,0,0, 1,0,0,2'd0, 0,0,0));
      basicTable.push_back(mk(1,0,0,0,1, 0,0,0,2'd0, 0,0,1));
      basicTable.push_back(mk(1,1,0,0,1, 1,0,0,2'd0, 0,0,1));
      basicTable.push_back(mk(1,0,0,0,1, 0,0,0,2'd0, 0,0,1));
      basicTable.push_back(mk(1,0,0,1,0, 0,0,0,2'd0, 0,1,0));
      for (int k = 1; k <= 6; k++) basicTable.push_back(mk(1,0,0,1,0, 0,0,0,2'd0, 0,1,0));
      basicTable.push_back(mk(1,0,0,1,0, 1,0,0,2'd0, 0,1,0));
      basicTable.push_back(mk(1,1,0,1,0, 0,0,0,2'd0, 0,1,0));
      basicTable.push_back(mk(1,0,0,0,0, 0,0,0,2'd0, 0,0,0));

      failTable.push_back(mk(1,0,1,0,0, 0,0,0,2'd1, 1,0,0));
      failTable.push_back(mk(1,1,1,0,0, 1,0,0,2'd1, 1,0,0));
      failTable.push_back(mk(1,1,1,0,0, 0,0,0,2'd1, 1,0,0));
      failTable.push_back(mk(1,0,0,0,0, 0,0,0,2'd1, 0,0,0));
      failTable.push_back(mk(1,1,1,0,0, 1,0,0,2'd2, 1,0,0));
      failTable.push_back(mk(1,0,1,0,0, 0,0,0,2'd2, 1,0,0));
      failTable.push_back(mk(1,0,0,0,0, 0,0,0,2'd2, 0,0,0));
      failTable.push_back(mk(1,0,0,1,0, 0,0,0,2'd0, 0,1,0));
      failTable.push_back(mk(1,1,0,1,0, 1,0,0,2'd0, 0,1,0));
      failTable.push_back(mk(1,0,0,0,0, 0,0,0,2'd0, 0,0,0));

      repeat (2) @(posedge clk);
      #1;

      $display("[TB] reset, forwarding, green entry and auto-acknowledge");
      for (int i = 0; i < basicTable.size(); i++) applyStimulus(basicTable[i]);

      $display("[TB] failure counting and green clear");
      for (int i = 0; i < failTable.size(); i++) applyStimulus(failTable[i]);

      $display("[TB] button coincident with display expiry");
      applyStimulus(mk(1,0,0,1,0, 0,0,0,2'd0, 0,1,0));
      for (int k = 1; k <= 6; k++) applyStimulus(mk(1,0,0,1,0, 0,0,0,2'd0, 0,1,0));
      applyStimulus(mk(1,1,0,1,0, 1,0,0,2'd0, 0,1,0));
      applyStimulus(mk(1,1,0,1,0, 0,0,0,2'd0, 0,1,0));
      applyStimulus(mk(1,0,0,0,0, 0,0,0,2'd0, 0,0,0));

      $display("[TB] lockout after third failure with coincident button");
      applyStimulus(mk(1,1,1,0,0, 1,0,0,2'd1, 1,0,0));
      applyStimulus(mk(1,0,0,0,0, 0,0,0,2'd1, 0,0,0));
      applyStimulus(mk(1,1,1,0,0, 1,0,0,2'd2, 1,0,0));
      applyStimulus(mk(1,0,0,0,0, 0,0,0,2'd2, 0,0,0));
      applyStimulus(mk(1,1,1,0,0, 0,1,1,2'd3, 1,0,0));
      for (int k = 1; k <= 20; k++) begin
         logic active;
         logic blinkR;
         logic inLed;
         active = (k < 20);
         blinkR = (((k - 1) / 4) % 2) == 0;
         inLed  = (k <= 10);
         applyStimulus(mk(1, logic'(k % 2), 0, inLed, inLed,
                          0, active, active, active ? 2'd3 : 2'd0,
                          blinkR, 0, 0));
      end
      applyStimulus(mk(1,0,0,0,0, 0,0,0,2'd0, 0,0,0));
      applyStimulus(mk(1,1,0,0,0, 1,0,0,2'd0, 0,0,0));

      $display("[TB] reset asserted in the middle of SHOW");
      applyStimulus(mk(1,0,1,0,0, 0,0,0,2'd1, 1,0,0));
      applyStimulus(mk(1,0,1,0,0, 0,0,0,2'd1, 1,0,0));
      applyStimulus(mk(1,0,1,0,0, 0,0,0,2'd1, 1,0,0));
      applyStimulus(mk(0,1,1,0,0, 0,1,0,2'd0, 1,0,0));
      applyStimulus(mk(0,0,1,0,0, 0,1,0,2'd0, 1,0,0));
      applyStimulus(mk(1,0,0,0,0, 0,0,0,2'd0, 0,0,0));
      applyStimulus(mk(1,1,0,0,0, 1,0,0,2'd0, 0,0,0));
      applyStimulus(mk(1,0,1,0,0, 0,0,0,2'd1, 1,0,0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end
endmodule

// File: doc/entry_lockout_controller.md
# entry_lockout_controller

Sequencing controller placed between the board's debounced user button and the pattern-checker FSM. It forwards action pulses to the checker, watches the checker's red/green/blue result LEDs, and auto-acknowledges a displayed result after a timeout. It counts consecutive failed code entries. After `MAX_FAILS` failures it holds the checker in reset for a lockout period and blinks red.

## Interface
- `MAX_FAILS`, default 3: consecutive failures that trigger lockout (≥1).
- `DISPLAY_CYCLES`, default 50_000_000: cycles a result is shown before auto-acknowledge (≥2).
- `LOCKOUT_CYCLES`, default 100_000_000: lockout duration in cycles (≥2).
- `BLINK_HALF`, default 12_500_000: half-period of the lockout red blink in cycles (≥1).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low; 0 = reset.
- `btn_pulse_in`  in  1  one-cycle user action pulse, already debounced and edge-detected upstream.
- `chk_led_r_in`, `chk_led_g_in`, `chk_led_b_in`  in  1 each  checker LED outputs (r = failure, g = success, b = entry in progress).
- `chk_action_out`  out  1  registered action pulse to the checker.
- `chk_reset_out`  out  1  registered, active-high synchronous reset to the checker.
- `led_r_out`, `led_g_out`, `led_b_out`  out  1 each  board LEDs.
- `locked_out`  out  1  high while in LOCKOUT.
- `fail_count_out`  out  $clog2(MAX_FAILS+1)  current consecutive-failure count.

## Operation
- Reset is applied at any edge with `reset`=0, including mid-operation, and sets the following:
  - state PASS
  - `fail_count_out`=0; all timers 0
  - `chk_action_out`=0; `chk_reset_out`=1
  - `locked_out`=0
- First edge with `reset`=1 sets `chk_reset_out`=0.
- States: PASS, SHOW, WAIT_CLEAR, LOCKOUT.
- **PASS**:
  - Board LEDs equal the checker LEDs.
  - `btn_pulse_in` is forwarded.
  - `chk_led_g_in`=1 clears the fail count and moves to SHOW.
  - `chk_led_r_in`=1 increments the fail count. If the new count equals `MAX_FAILS`, go to LOCKOUT; otherwise go to SHOW.
  - A result plus `btn_pulse_in` in the same cycle:
    - The count is updated as above.
    - The pulse is forwarded and the state goes to WAIT_CLEAR.
    - Exception: if the transition is to LOCKOUT, the pulse is dropped.
- **SHOW**:
  - Board LEDs equal the checker LEDs.
  - The display timer runs.
  - `btn_pulse_in` is forwarded, and the state goes to WAIT_CLEAR.
  - On timer expiry, the controller generates one action pulse itself and goes to WAIT_CLEAR.
  - Button and expiry in the same cycle produce exactly one pulse.
- **WAIT_CLEAR**:
  - Board LEDs equal the checker LEDs.
  - `btn_pulse_in` is dropped.
  - When `chk_led_r_in` and `chk_led_g_in` are both 0, go to PASS.
- **LOCKOUT**:
  - `chk_reset_out`=1 and `chk_action_out`=0; `btn_pulse_in` is ignored.
  - `locked_out`=1.
  - `led_g_out`=`led_b_out`=0. `led_r_out` blinks: 1 for the first `BLINK_HALF` cycles, then 0 for `BLINK_HALF`, repeating.
  - On timer expiry: `fail_count_out`=0, `chk_reset_out`=0, go to PASS.
- Fail count saturates at `MAX_FAILS` and never wraps.
- Timers and the blink counter clear on every state entry.
- Board LED outputs are combinational from the state and the checker inputs. All other outputs are registered.

## Timing
- A forwarded pulse: `btn_pulse_in` high in cycle N gives `chk_action_out` high for exactly cycle N+1.
- A result LED sampled high at edge E takes effect at that edge: the state changes at E and `fail_count_out` updates at E.
- SHOW entered at edge E: the auto pulse is high for the cycle after edge E+`DISPLAY_CYCLES`−1. Earliest WAIT_CLEAR exit is 2 edges after the pulse (checker latency).
- LOCKOUT entered at edge E:
  - `chk_reset_out` is high from E.
  - Return to PASS, with `chk_reset_out` low, occurs at edge E+`LOCKOUT_CYCLES`.
- `chk_action_out` is never high for two consecutive cycles.
- `chk_action_out` is never high while `chk_reset_out`=1.

## Test plan
All scenarios use `MAX_FAILS`=3, `DISPLAY_CYCLES`=8, `LOCKOUT_CYCLES`=20, `BLINK_HALF`=4, paired with the real checker.

- Reset with `reset`=0 mid-SHOW for 2 cycles, then release -> `chk_reset_out`=1 while held and 0 one edge after release; `fail_count_out`=0; state PASS.
- Button pulse in PASS -> `chk_action_out` high exactly one cycle later. Entering 0101, 1000, 0001 -> `led_g_out`=1, `fail_count_out`=0. No button for 8 cycles -> one auto pulse, then green clears.
- Two wrong entries, each acknowledged by button -> `fail_count_out` = 1, then 2; one correct entry -> `fail_count_out`=0.
- Three consecutive wrong entries -> on the third red, `locked_out`=1 and `led_r_out` pattern 1111 0000 1111 ...; button presses produce no `chk_action_out`; after 20 cycles `locked_out`=0, `fail_count_out`=0, `chk_reset_out`=0.
- In SHOW, button pulse coincident with timer expiry -> exactly one `chk_action_out` cycle. Extra button presses in WAIT_CLEAR are dropped.
- Button pulse in the same cycle as the third red -> LOCKOUT entered and the pulse dropped (`chk_action_out` stays 0).
